score_display_sequencer: RTL and testbench



---
 rtl/score_display_sequencer_pkg.sv | 27 ++
 rtl/score_display_sequencer_bin2bcd.sv | 75 +++++++
 rtl/score_display_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_score_display_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/score_display_sequencer_pkg.sv
// Shared types, constants and parameter-legality helpers for the score display sequencer.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANNOUNCE = 2'd1,
        ST_DIGIT    = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // The BCD converter must finish well inside the announce window.
    function automatic bit params_legal(input int np, input int sw, input int nd,
                                        input int tc, input int bc, input int dt);
        return (np >= 1) && (np <= 9) && (nd >= 1) && (nd <= 4) && (sw >= 1) &&
               (tc >= 2) && (bc >= 1) && (dt >= 1) && (tc * 2 * bc > sw + 2);
    endfunction

endpackage

// File: rtl/score_display_sequencer_bin2bcd.sv
// Sequential double-dabble binary to BCD converter, one bit per cycle,
// saturating to all nines when the value does not fit in NUM_DIGITS digits.
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [SCORE_W-1:0]      bin_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    valid_o
);

    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;

    logic [SCORE_W-1:0] r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_valid;
    logic               r_sat;
    logic [BCD_W-1:0]   w_adjusted;
    logic               w_limitHit;

    assign w_limitHit = {{(64-SCORE_W){1'b0}}, bin_i} >= 64'(pow10(NUM_DIGITS));

    always_comb begin
        w_adjusted = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adjusted[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else if (clear_i) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else if (start_i) begin
            r_shift <= bin_i;
            r_bcd   <= '0;
            r_count <= CNT_W'(SCORE_W);
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_sat   <= w_limitHit;
        end else if (r_busy) begin
            r_bcd   <= BCD_W'({w_adjusted, r_shift[SCORE_W-1]});
            r_shift <= r_shift << 1;
            r_count <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
            end
        end
    end

    assign bcd_o   = r_sat ? {NUM_DIGITS{4'd9}} : r_bcd;
    assign valid_o = r_valid;

endmodule

// File: rtl/score_display_sequencer.sv
// Sequences N players' scores onto a multiplexed BCD digit bus: blinking player
// announce, score digits MSD to LSD with leading-zero blanking, then a blank gap.
module score_display_sequencer
    import score_display_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 8,
    parameter int NUM_DIGITS  = 2,
    parameter int TICK_CYCLES = 1048576,
    parameter int BLINK_COUNT = 5,
    parameter int DIGIT_TICKS = 2,
    parameter int LZ_BLANK    = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic                           hold_i,
    input  logic [NUM_PLAYERS*SCORE_W-1:0] scores_i,
    output logic [3:0]                     digit_o,
    output logic [NUM_DIGITS-1:0]          segment_select_o,
    output logic [3:0]                     player_o,
    output logic [1:0]                     state_o,
    output logic                           frame_done_o
);

    localparam int TICK_W  = $clog2(TICK_CYCLES);
    localparam int PHASE_W = $clog2(2 * BLINK_COUNT);
    localparam int DTICK_W = $clog2(DIGIT_TICKS + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS + 1);

    if (!params_legal(NUM_PLAYERS, SCORE_W, NUM_DIGITS, TICK_CYCLES, BLINK_COUNT, DIGIT_TICKS)) begin : g_param_check
        $error("score_display_sequencer: illegal parameter combination");
    end

    state_t                  r_state, w_stateNext;
    logic [TICK_W-1:0]       r_tickCnt, w_tickNext;
    logic [PHASE_W-1:0]      r_phase, w_phaseNext;
    logic [IDX_W-1:0]        r_idx, w_idxNext;
    logic [DTICK_W-1:0]      r_dticks, w_dticksNext;
    logic [3:0]              r_player, w_playerNext;
    logic [SCORE_W-1:0]      r_snapshot;
    logic                    r_bcdStart;
    logic [3:0]              r_digit, w_digitNext;
    logic [NUM_DIGITS-1:0]   r_segSel, w_selNext;
    logic                    r_frameDone, w_frameDoneNext;
    logic                    w_tick, w_enterAnnounce, w_clear;
    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic                    w_bcdValid, w_nonZero, w_leadingZero;
    logic [3:0]              w_bcdDigit;

    bin2bcd_seq #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (w_clear),
        .start_i (r_bcdStart),
        .bin_i   (r_snapshot),
        .bcd_o   (w_bcd),
        .valid_o (w_bcdValid)
    );

    assign w_tick = (r_tickCnt == TICK_W'(TICK_CYCLES - 1));

    always_comb begin
        w_stateNext     = r_state;
        w_tickNext      = hold_i ? r_tickCnt : (w_tick ? '0 : r_tickCnt + TICK_W'(1));
        w_phaseNext     = r_phase;
        w_idxNext       = r_idx;
        w_dticksNext    = r_dticks;
        w_playerNext    = r_player;
        w_enterAnnounce = 1'b0;
        w_frameDoneNext = 1'b0;
        w_clear         = 1'b0;
        if (!enable_i) begin
            w_stateNext  = ST_IDLE;
            w_tickNext   = '0;
            w_phaseNext  = '0;
            w_idxNext    = '0;
            w_dticksNext = '0;
            w_playerNext = '0;
            w_clear      = 1'b1;
        end else if (!hold_i) begin
            case (r_state)
                ST_IDLE: begin
                    w_stateNext     = ST_ANNOUNCE;
                    w_tickNext      = '0;
                    w_phaseNext     = '0;
                    w_playerNext    = '0;
                    w_enterAnnounce = 1'b1;
                end
                ST_ANNOUNCE: if (w_tick) begin
                    if (r_phase == PHASE_W'(2 * BLINK_COUNT - 1)) begin
                        w_stateNext  = ST_DIGIT;
                        w_idxNext    = IDX_W'(NUM_DIGITS - 1);
                        w_dticksNext = '0;
                    end else begin
                        w_phaseNext = r_phase + PHASE_W'(1);
                    end
                end
                ST_DIGIT: if (w_tick) begin
                    if (r_dticks == DTICK_W'(DIGIT_TICKS - 1)) begin
                        w_dticksNext = '0;
                        if (r_idx == '0) w_stateNext = ST_GAP;
                        else             w_idxNext   = r_idx - IDX_W'(1);
                    end else begin
                        w_dticksNext = r_dticks + DTICK_W'(1);
                    end
                end
                ST_GAP: if (w_tick) begin
                    w_stateNext     = ST_ANNOUNCE;
                    w_phaseNext     = '0;
                    w_enterAnnounce = 1'b1;
                    if (r_player == 4'(NUM_PLAYERS - 1)) begin
                        w_playerNext    = '0;
                        w_frameDoneNext = 1'b1;
                    end else begin
                        w_playerNext = r_player + 4'd1;
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next-state values so they register alongside the state.
    always_comb begin
        w_digitNext = BLANK_CODE;
        w_selNext   = '0;
        w_nonZero   = 1'b0;
        w_bcdDigit  = w_bcd[int'(w_idxNext)*4 +: 4];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(w_idxNext) && w_bcd[4*i +: 4] != 4'd0) w_nonZero = 1'b1;
        end
        w_leadingZero = (LZ_BLANK != 0) && (w_idxNext != '0) && !w_nonZero;
        case (w_stateNext)
            ST_ANNOUNCE: begin
                w_selNext   = NUM_DIGITS'(1);
                w_digitNext = w_phaseNext[0] ? BLANK_CODE : w_playerNext + 4'd1;
            end
            ST_DIGIT: begin
                w_selNext   = NUM_DIGITS'(1) << w_idxNext;
                w_digitNext = (w_leadingZero || !w_bcdValid) ? BLANK_CODE : w_bcdDigit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_tickCnt   <= '0;
            r_phase     <= '0;
            r_idx       <= '0;
            r_dticks    <= '0;
            r_player    <= '0;
            r_snapshot  <= '0;
            r_bcdStart  <= 1'b0;
            r_digit     <= BLANK_CODE;
            r_segSel    <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_tickCnt   <= w_tickNext;
            r_phase     <= w_phaseNext;
            r_idx       <= w_idxNext;
            r_dticks    <= w_dticksNext;
            r_player    <= w_playerNext;
            r_bcdStart  <= w_enterAnnounce;
            r_digit     <= w_digitNext;
            r_segSel    <= w_selNext;
            r_frameDone <= w_frameDoneNext;
            if (w_enterAnnounce) r_snapshot <= scores_i[int'(w_playerNext)*SCORE_W +: SCORE_W];
        end
    end

    assign digit_o          = r_digit;
    assign segment_select_o = r_segSel;
    assign player_o         = r_player;
    assign state_o          = r_state;
    assign frame_done_o     = r_frameDone;

endmodule

// File: tb/tb_score_display_sequencer.sv
// Directed, table-driven bench for score_display_sequencer with short tick timing.
module tb_score_display_sequencer;

    localparam int NP = 2, SW = 8, ND = 2, TC = 4, BC = 2, DT = 1, LZ = 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_ANN = 2'd1, S_DIG = 2'd2, S_GAP = 2'd3;
    localparam logic [3:0] BL = 4'hF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             hold;
    logic [NP*SW-1:0] scores;
    logic [3:0]       digit;
    logic [ND-1:0]    sel;
    logic [3:0]       player;
    logic [1:0]       state;
    logic             frameDone;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            cycles;
        logic [1:0]    st;
        logic [3:0]    pl;
        logic [3:0]    dg;
        logic [ND-1:0] sl;
        logic          fd;
    } seg_t;

    seg_t vecs[$];

    always #5 clk = ~clk;

    score_display_sequencer #(
        .NUM_PLAYERS(NP), .SCORE_W(SW), .NUM_DIGITS(ND), .TICK_CYCLES(TC),
        .BLINK_COUNT(BC), .DIGIT_TICKS(DT), .LZ_BLANK(LZ)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .hold_i           (hold),
        .scores_i         (scores),
        .digit_o          (digit),
        .segment_select_o (sel),
        .player_o         (player),
        .state_o          (state),
        .frame_done_o     (frameDone)
    );

    task automatic stepCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic en, input logic hd, input logic [NP*SW-1:0] sc);
        enable = en;
        hold   = hd;
        scores = sc;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] st, input logic [3:0] pl,
                               input logic [3:0] dg, input logic [ND-1:0] sl, input logic fd);
        checks++;
        if (state !== st || player !== pl || digit !== dg || sel !== sl || frameDone !== fd) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got st=%0d pl=%0d dg=%h sel=%b fd=%b, want st=%0d pl=%0d dg=%h sel=%b fd=%b",
                     name, $time, state, player, digit, sel, frameDone, st, pl, dg, sl, fd);
        end
    endtask

    task automatic pushSeg(input int n, input logic [1:0] st, input logic [3:0] pl,
                           input logic [3:0] dg, input logic [ND-1:0] sl, input logic fd);
        seg_t s;
        s.cycles = n; s.st = st; s.pl = pl; s.dg = dg; s.sl = sl; s.fd = fd;
        vecs.push_back(s);
    endtask

    task automatic pushPlayer(input logic [3:0] pl, input logic [3:0] d1, input logic [3:0] d0,
                              input logic fdFirst);
        pushSeg(TC, S_ANN, pl, pl + 4'd1, 2'b01, fdFirst);
        pushSeg(TC, S_ANN, pl, BL,        2'b01, 1'b0);
        pushSeg(TC, S_ANN, pl, pl + 4'd1, 2'b01, 1'b0);
        pushSeg(TC, S_ANN, pl, BL,        2'b01, 1'b0);
        pushSeg(TC, S_DIG, pl, d1,        2'b10, 1'b0);
        pushSeg(TC, S_DIG, pl, d0,        2'b01, 1'b0);
        pushSeg(TC, S_GAP, pl, BL,        2'b00, 1'b0);
    endtask

    task automatic runTable(input string name);
        for (int s = 0; s < vecs.size(); s++) begin
            for (int c = 0; c < vecs[s].cycles; c++) begin
                stepCycle();
                checkOutput(name, vecs[s].st, vecs[s].pl, vecs[s].dg, vecs[s].sl,
                            vecs[s].fd && (c == 0));
            end
        end
        vecs.delete();
    endtask

    task automatic restart(input logic [NP*SW-1:0] sc);
        stepCycle();
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, sc);
        stepCycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, {8'd42, 8'd7});
        repeat (2) stepCycle();
        checkOutput("reset_values", S_IDLE, 4'd0, BL, 2'b00, 1'b0);

        // Run into p0's MSD, then pull reset asynchronously between edges.
        applyStimulus(1'b1, 1'b0, {8'd42, 8'd7});
        rst_n = 1'b1;
        repeat (18) stepCycle();
        checkOutput("pre_reset_digit", S_DIG, 4'd0, BL, 2'b10, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", S_IDLE, 4'd0, BL, 2'b00, 1'b0);
        stepCycle();
        checkOutput("held_in_reset", S_IDLE, 4'd0, BL, 2'b00, 1'b0);
        rst_n = 1'b1;

        pushPlayer(4'd0, BL, 4'd7, 1'b0);
        pushPlayer(4'd1, 4'd4, 4'd2, 1'b0);
        pushSeg(TC, S_ANN, 4'd0, 4'd1, 2'b01, 1'b1);
        runTable("frame_42_7");

        restart({8'd0, 8'd250});
        pushPlayer(4'd0, 4'd9, 4'd9, 1'b0);
        pushPlayer(4'd1, BL, 4'd0, 1'b0);
        pushSeg(1, S_ANN, 4'd0, 4'd1, 2'b01, 1'b1);
        runTable("sat_and_zero");

        // Hold for 10 cycles on the second cycle of p0's LSD.
        restart({8'd42, 8'd7});
        repeat (22) stepCycle();
        checkOutput("hold_pre", S_DIG, 4'd0, 4'd7, 2'b01, 1'b0);
        applyStimulus(1'b1, 1'b1, {8'd42, 8'd7});
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("hold_frozen", S_DIG, 4'd0, 4'd7, 2'b01, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, {8'd42, 8'd7});
        repeat (2) begin
            stepCycle();
            checkOutput("hold_resume", S_DIG, 4'd0, 4'd7, 2'b01, 1'b0);
        end
        stepCycle();
        checkOutput("hold_to_gap", S_GAP, 4'd0, BL, 2'b00, 1'b0);

        // New p0 score mid-DIGIT only appears after p0's next announce latch.
        restart({8'd42, 8'd7});
        repeat (18) stepCycle();
        applyStimulus(1'b1, 1'b0, {8'd42, 8'd35});
        pushSeg(2, S_DIG, 4'd0, BL, 2'b10, 1'b0);
        pushSeg(TC, S_DIG, 4'd0, 4'd7, 2'b01, 1'b0);
        pushSeg(TC, S_GAP, 4'd0, BL, 2'b00, 1'b0);
        pushPlayer(4'd1, 4'd4, 4'd2, 1'b0);
        pushPlayer(4'd0, 4'd3, 4'd5, 1'b1);
        runTable("score_latch");

        // Disable during p1's announce, then re-enable.
        restart({8'd42, 8'd7});
        repeat (30) stepCycle();
        checkOutput("pre_disable", S_ANN, 4'd1, 4'd2, 2'b01, 1'b0);
        applyStimulus(1'b0, 1'b0, {8'd42, 8'd7});
        stepCycle();
        checkOutput("disable_idle", S_IDLE, 4'd0, BL, 2'b00, 1'b0);
        stepCycle();
        checkOutput("disable_stay", S_IDLE, 4'd0, BL, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, {8'd42, 8'd7});
        pushPlayer(4'd0, BL, 4'd7, 1'b0);
        runTable("reenable");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
